// File: rtl/fei4_rx_word_align_if.sv
// Serial input and aligned-symbol output bundle for the FEI4 receive word aligner.
// master drives the serial stream; slave is the aligner itself.
interface fei4_rx_word_align_if;
  logic       sdata;
  logic       enable;
  logic [9:0] data_out;
  logic       data_valid;
  logic       is_comma;
  logic       locked;
  logic [7:0] realign_cnt;

  modport master (
    output sdata, enable,
    input  data_out, data_valid, is_comma, locked, realign_cnt
  );

  modport slave (
    input  sdata, enable,
    output data_out, data_valid, is_comma, locked, realign_cnt
  );
endinterface

// File: rtl/fei4_rx_word_align.sv
// Comma-based 10-bit word aligner for the FEI4 serial stream.
// Hunts for a K28 comma, then frames every 10 bits and realigns after repeated off-boundary commas.
module fei4_rx_word_align #(
  parameter int MISALIGN_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  fei4_rx_word_align_if.slave   bus
);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t     state_r, state_s;
  logic [9:0] sr_r, sr_s;
  logic [3:0] cnt_r, cnt_s;
  logic [7:0] mis_r, mis_s;
  logic [9:0] data_out_r, data_out_s;
  logic       data_valid_r, data_valid_s;
  logic       is_comma_r, is_comma_s;
  logic [7:0] realign_r, realign_s;

  logic [9:0] sr_shift_s;
  logic       comma_s;
  logic [7:0] mis_inc_s;

  // Both comma polarities share the 7-bit singular prefix.
  function automatic logic is_comma_prefix(input logic [6:0] p);
    return (p == 7'b0011111) || (p == 7'b1100000);
  endfunction

  assign sr_shift_s = {sr_r[8:0], bus.sdata};
  assign comma_s    = is_comma_prefix(sr_shift_s[9:3]);
  assign mis_inc_s  = mis_r + 8'd1;

  // Next-state, framing counter and output word selection.
  always_comb begin
    state_s      = state_r;
    sr_s         = sr_r;
    cnt_s        = cnt_r;
    mis_s        = mis_r;
    data_out_s   = data_out_r;
    data_valid_s = 1'b0;
    is_comma_s   = 1'b0;
    realign_s    = realign_r;

    if (!bus.enable) begin
      state_s = HUNT;
      cnt_s   = 4'd0;
      mis_s   = 8'd0;
    end else begin
      sr_s = sr_shift_s;
      case (state_r)
        HUNT: begin
          if (comma_s) begin
            state_s      = LOCKED;
            cnt_s        = 4'd0;
            mis_s        = 8'd0;
            data_out_s   = sr_shift_s;
            data_valid_s = 1'b1;
            is_comma_s   = 1'b1;
          end else begin
            state_s = HUNT;
          end
        end
        LOCKED: begin
          if (cnt_r == 4'd9) begin
            cnt_s        = 4'd0;
            data_out_s   = sr_shift_s;
            data_valid_s = 1'b1;
            is_comma_s   = comma_s;
            if (comma_s) begin
              mis_s = 8'd0;
            end else begin
              mis_s = mis_r;
            end
          end else begin
            cnt_s = cnt_r + 4'd1;
            // An off-boundary comma that reaches the limit becomes the new word boundary.
            if (comma_s) begin
              if (int'(mis_inc_s) >= MISALIGN_LIMIT) begin
                cnt_s        = 4'd0;
                mis_s        = 8'd0;
                data_out_s   = sr_shift_s;
                data_valid_s = 1'b1;
                is_comma_s   = 1'b1;
                if (realign_r != 8'hFF) begin
                  realign_s = realign_r + 8'd1;
                end else begin
                  realign_s = realign_r;
                end
              end else begin
                mis_s = mis_inc_s;
              end
            end else begin
              mis_s = mis_r;
            end
          end
        end
        default: begin
          state_s = HUNT;
          cnt_s   = 4'd0;
          mis_s   = 8'd0;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= HUNT;
      sr_r         <= 10'h000;
      cnt_r        <= 4'd0;
      mis_r        <= 8'd0;
      data_out_r   <= 10'h000;
      data_valid_r <= 1'b0;
      is_comma_r   <= 1'b0;
      realign_r    <= 8'd0;
    end else begin
      state_r      <= state_s;
      sr_r         <= sr_s;
      cnt_r        <= cnt_s;
      mis_r        <= mis_s;
      data_out_r   <= data_out_s;
      data_valid_r <= data_valid_s;
      is_comma_r   <= is_comma_s;
      realign_r    <= realign_s;
    end
  end

  assign bus.data_out    = data_out_r;
  assign bus.data_valid  = data_valid_r;
  assign bus.is_comma    = is_comma_r;
  assign bus.locked      = (state_r == LOCKED);
  assign bus.realign_cnt = realign_r;

endmodule

// File: doc/fei4_rx_word_align.md
FEI4_RX_WORD_ALIGN -- requirements
Module: fei4_rx_word_align

Interface
REQ-001 The block SHALL have a single clock and an asynchronous, active-high reset; no other clock domains.
REQ-002 Parameter MISALIGN_LIMIT, default 4: number of consecutive off-boundary commas that forces realignment.
REQ-003 clk  input  1  system clock; one recovered serial bit per rising edge.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 sdata  input  1  recovered serial bit from the oversampling sync stage; sampled every clk rising edge.
REQ-006 enable  input  1  high = run; low = synchronous return to HUNT and output suppression.
REQ-007 data_out  output  10  aligned 8b10b symbol; first-received bit in bit 9.
REQ-008 data_valid  output  1  one-cycle strobe; data_out valid in the same cycle.
REQ-009 is_comma  output  1  qualifies data_out; high when data_out[9:3] is a comma prefix.
REQ-010 locked  output  1  high while state is LOCKED.
REQ-011 realign_cnt  output  8  count of realignment events; saturates at 255.

Function
REQ-012 Shift register sr[9:0] SHALL update every clk as sr <= {sr[8:0], sdata} whenever enable is high.
REQ-013 Comma detect SHALL be combinational on the updated sr: sr[9:3] equal to 7'b0011111 or 7'b1100000 (covers K28.1/K28.5/K28.7, both disparities).
REQ-014 States SHALL be HUNT and LOCKED; reset and enable low both force HUNT.
REQ-015 HUNT: on the first clk with comma detect, the block SHALL register data_out <= sr, assert data_valid and is_comma for one cycle, clear bit counter cnt to 0, and enter LOCKED.
REQ-016 HUNT: data_valid SHALL remain low while no comma is detected.
REQ-017 LOCKED: cnt SHALL increment modulo 10 each clk; when cnt wraps 9->0 the block SHALL output data_out <= sr with a one-cycle data_valid, so strobes are exactly 10 clk apart.
REQ-018 LOCKED: a comma detected at a boundary (cnt wrap) SHALL clear the misalignment counter mis_cnt.
REQ-019 LOCKED: a comma detected off-boundary SHALL increment mis_cnt; a boundary word without a comma SHALL leave mis_cnt unchanged.
REQ-020 When an off-boundary comma brings mis_cnt to MISALIGN_LIMIT, the block SHALL realign in that same cycle: emit that comma as a word (data_valid, is_comma high), clear cnt and mis_cnt, stay LOCKED, and increment realign_cnt.
REQ-021 HUNT-to-LOCKED entry SHALL NOT increment realign_cnt; realign_cnt SHALL saturate at 255 and clear only on rst.
REQ-022 enable deasserted SHALL, on the next clk edge, force HUNT, clear cnt and mis_cnt, drop locked and data_valid; sr and data_out hold.
REQ-023 Latency: data_valid SHALL rise 1 clk after the last bit of the symbol is sampled on sdata.
REQ-024 is_comma SHALL be low whenever data_valid is low.

Reset
REQ-025 On rst: state HUNT, sr 10'h000, cnt 0, mis_cnt 0, data_out 10'h000, data_valid 0, is_comma 0, locked 0, realign_cnt 0.
REQ-026 rst asserted mid-word SHALL discard the partial symbol; after release the block SHALL hunt from scratch, with no data_valid until a new comma is received.

Verification
REQ-027 Idle stream of K28.5 (0011111010 / 1100000101 alternating) after reset -> first data_valid 1 clk after the 10th bit, locked=1, then data_valid every 10 clk, is_comma=1 each time, realign_cnt=0.
REQ-028 Locked on K28.5, then data symbol D21.5 (1010101010) -> data_valid with data_out=10'h2AA, is_comma=0; lock retained.
REQ-029 Locked, then stream slipped by 3 bits carrying K28.5 -> 3 off-boundary commas with no change in alignment; the 4th realigns, realign_cnt=1, and data_valid is then every 10 clk on the new phase.
REQ-030 Off-boundary commas interleaved with an on-boundary comma before reaching the limit -> mis_cnt clears, no realign, realign_cnt unchanged.
REQ-031 enable low for 5 clk while locked -> locked=0 next clk, no data_valid; after enable high, relock on the next comma.
REQ-032 rst pulse mid-symbol, then 300 forced realigns -> all outputs at reset values during rst; realign_cnt saturates at 255.
